fetch_stage: RTL and testbench

//  Front-end fetch unit sitting directly upstream of the instruction queue (fifo).

---
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Front-end fetch unit: keeps the PC, runs one I-cache read at a time and pushes
// {pc, instr} into the instruction queue, dropping fetches made stale by redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1ECEB000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        write_en,
  output logic [63:0] write_data,
  input  logic        queue_full,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pc_next, w_pc_next_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_inc;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign w_pc_inc   = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_pc_next <= '0;
      r_buf     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pc_next <= w_pc_next_nxt;
      r_buf     <= w_buf_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pc_next_nxt = r_pc_next;
    w_buf_nxt     = r_buf;
    imem_addr     = '0;
    imem_rmask    = '0;
    write_en      = 1'b0;
    write_data    = '0;
    unique case (r_state)
      S_REQ: begin
        imem_addr  = r_pc;
        imem_rmask = 4'hF;
        if (redirect_valid) begin
          // A response arriving with the redirect closes the read, so refetch at once.
          if (imem_resp) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            w_pc_next_nxt = w_redir_pc;
            w_state_nxt   = S_DISCARD;
          end
        end else if (imem_resp) begin
          if (queue_full) begin
            w_buf_nxt   = imem_rdata;
            w_state_nxt = S_HOLD;
          end else begin
            write_en   = 1'b1;
            write_data = {r_pc, imem_rdata};
            w_pc_nxt   = w_pc_inc;
          end
        end
      end
      S_HOLD: begin
        imem_addr = r_pc;
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_REQ;
        end else if (!queue_full) begin
          write_en    = 1'b1;
          write_data  = {r_pc, r_buf};
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_REQ;
        end
      end
      S_DISCARD: begin
        // Bus keeps the stale address until its response retires the read.
        imem_addr  = r_pc;
        imem_rmask = 4'hF;
        if (redirect_valid) w_pc_next_nxt = w_redir_pc;
        if (imem_resp) begin
          w_pc_nxt    = redirect_valid ? w_redir_pc : r_pc_next;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
    if (rst) begin
      imem_addr  = '0;
      imem_rmask = '0;
      write_en   = 1'b0;
      write_data = '0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a path/epoch model of the fetch stream feeds
// a golden queue that a negedge monitor drains against the DUT's pushes.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h1ECEB000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        write_en;
  logic [63:0] write_data;
  logic        queue_full;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .write_en       (write_en),
    .write_data     (write_data),
    .queue_full     (queue_full),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Reference state: the program path the front end should be delivering.
  logic [63:0] gold[$];
  logic [31:0] path_pc;
  int          epoch;
  bit          pend;
  logic [31:0] paddr;
  int          pep;
  int          cnt;
  int          lat_fix;
  bit          tput_mode;
  bit          done;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_push = 0;
  bit have_last = 1'b0;
  int n_push = 0;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // rmode: 0 = no redirect, 1 = redirect, 2 = redirect only if a response is delivered
  task automatic step(input bit f_full, input int rmode, input logic [31:0] rpc, input bit do_rst);
    @(posedge clk);
    #1;
    rst = do_rst;
    #1;
    if (imem_resp) pend = 1'b0;
    imem_resp      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    queue_full     = f_full;
    imem_rdata     = $urandom;
    if (do_rst) begin
      pend    = 1'b0;
      epoch   = epoch + 1;
      path_pc = RESET_PC;
      gold.delete();
    end else begin
      if (!pend && imem_rmask == 4'hF) begin
        pend  = 1'b1;
        paddr = imem_addr;
        pep   = epoch;
        cnt   = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
      end else if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = mw(paddr);
        end
      end
      if (rmode == 1 || (rmode == 2 && imem_resp)) begin
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
      end
      if (redirect_valid) begin
        epoch   = epoch + 1;
        path_pc = {rpc[31:2], 2'b00};
        gold.delete();
      end else if (imem_resp && pep == epoch) begin
        gold.push_back({path_pc, mw(path_pc)});
        path_pc = path_pc + 32'd4;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (rst) begin
      chk("rst_addr", 64'(imem_addr), 64'd0);
      chk("rst_ctl", {59'd0, imem_rmask, write_en}, 64'd0);
      chk("rst_wdata", write_data, 64'd0);
    end else begin
      if (pend) chk("req_stable", {28'd0, imem_rmask, imem_addr}, {28'd0, 4'hF, paddr});
      if (gold.size() > 0 && !imem_resp) chk("hold_idle", 64'(imem_rmask), 64'd0);
      if (write_en) begin
        n_push++;
        chk("push_not_full", 64'(queue_full), 64'd0);
        if (gold.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_push: got %h expected no push (cycle %0d)", write_data, cyc);
        end else begin
          e = gold.pop_front();
          chk("push_entry", write_data, e);
        end
        if (tput_mode && have_last) chk("push_spacing", 64'(cyc - last_push), 64'd2);
        last_push = cyc;
        have_last = tput_mode;
      end
    end
    if (done) begin
      chk("drain", 64'(gold.size()), 64'd0);
      chk("progress", 64'(n_push >= 50), 64'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0; queue_full = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    path_pc = RESET_PC; epoch = 0; pend = 1'b0; paddr = '0; pep = 0; cnt = 0;
    lat_fix = 1; tput_mode = 1'b0; done = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    // in-order stream, one push every two cycles
    tput_mode = 1'b1;
    repeat (10) step(0, 0, 0, 0);
    tput_mode = 1'b0;
    // queue full across a response
    step(0, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    // redirect while a slow read is pending
    lat_fix = 3;
    step(0, 0, 0, 0);
    step(0, 1, 32'h1ECEB103, 0);
    repeat (8) step(0, 0, 0, 0);
    // redirect with response, then redirect during hold
    lat_fix = 1;
    repeat (2) step(0, 2, 32'h1ECEB400, 0);
    repeat (4) step(0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 32'h1ECEB600, 0);
    repeat (4) step(0, 0, 0, 0);
    // two redirects inside one discard window; newest wins
    lat_fix = 6;
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0200, 0);
    step(0, 1, 32'h0000_0300, 0);
    repeat (12) step(0, 0, 0, 0);
    // PC wrap past the top of the address space
    lat_fix = 1;
    step(0, 1, 32'hFFFF_FFFA, 0);
    repeat (10) step(0, 0, 0, 0);
    // reset mid-request and mid-hold
    lat_fix = 3;
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 0);
    lat_fix = 1;
    repeat (4) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (6) step(0, 0, 0, 0);
    // randomized traffic
    lat_fix = 0;
    repeat (3000)
      step($urandom_range(0, 3) == 0, ($urandom_range(0, 19) == 0) ? 1 : 0, $urandom,
           $urandom_range(0, 299) == 0);
    lat_fix = 1;
    repeat (20) step(0, 0, 0, 0);
    done = 1'b1;
    #100;
    $display("FAIL watchdog: monitor did not finish");
    $fatal(1);
  end

endmodule
